// File: rtl/weighted_rr_arbiter.sv
// weighted_rr_arbiter
//
// Weighted round-robin arbiter. It merges NUM_CH valid/ready producer streams
// into one registered valid/ready output. A channel that wins the grant may
// send up to its weight in beats (PACKET_MODE=0) or in packets delimited by
// in_last (PACKET_MODE=1). After that the search restarts at the next channel.
// Each hand-over costs one IDLE select cycle.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   per-channel valid
//   in_ready   per-channel ready, one-hot on the granted channel or zero
//   in_data    channel i occupies [i*DATA_W +: DATA_W]
//   in_last    per-channel end-of-packet (used only in packet mode)
//   out_valid  output register holds a beat
//   out_ready  downstream accepts the beat
//   out_data   registered data
//   out_ch     source channel of out_data
//   out_last   registered in_last (always 1 in beat mode)

module weighted_rr_arbiter #(
    parameter int NUM_CH            = 4,
    parameter int DATA_W            = 8,
    parameter int WEIGHT_W          = 4,
    parameter int WEIGHTS [NUM_CH]  = '{default: 1},
    parameter bit PACKET_MODE       = 1'b0
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_CH-1:0]         in_valid,
    output logic [NUM_CH-1:0]         in_ready,
    input  logic [NUM_CH*DATA_W-1:0]  in_data,
    input  logic [NUM_CH-1:0]         in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_data,
    output logic [$clog2(NUM_CH)-1:0] out_ch,
    output logic                      out_last
);

    localparam int CH_W = $clog2(NUM_CH);

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_e;

    state_e              state_q;
    logic [CH_W-1:0]     cur_q;
    logic [CH_W-1:0]     ptr_q;
    logic [WEIGHT_W-1:0] credit_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic [CH_W-1:0]     out_ch_q;
    logic                out_last_q;

    // Effective weights: a weight of 0 would starve the channel, so it
    // is promoted to 1.
    logic [WEIGHT_W-1:0] weight_eff [NUM_CH];
    logic [DATA_W-1:0]   data_ch    [NUM_CH];

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign weight_eff[g] = (WEIGHTS[g] == 0) ? WEIGHT_W'(1) : WEIGHT_W'(WEIGHTS[g]);
        assign data_ch[g]    = in_data[g*DATA_W +: DATA_W];
    end

    // Rotating priority search. The first requester at or after ptr_q wins.
    // The sum needs one extra bit so it can exceed NUM_CH before wrapping.
    logic            found;
    logic [CH_W-1:0] pick;
    logic [CH_W:0]   search_idx;

    // NOTE: every always_comb output gets a default first, so no path
    // through the block leaves a value held and infers a latch.
    always_comb begin
        found      = 1'b0;
        pick       = ptr_q;
        search_idx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            search_idx = {1'b0, ptr_q} + (CH_W+1)'(i);
            if (search_idx >= (CH_W+1)'(NUM_CH)) begin
                search_idx = search_idx - (CH_W+1)'(NUM_CH);
            end
            if (!found && in_valid[search_idx[CH_W-1:0]]) begin
                found = 1'b1;
                pick  = search_idx[CH_W-1:0];
            end
        end
    end

    // The output register can take a beat when it is empty or draining.
    logic            can_load;
    logic            cur_valid;
    logic            xfer;
    logic            credit_dec;
    logic            burst_end;
    logic [CH_W-1:0] next_ptr;

    assign can_load   = !out_valid_q || out_ready;
    assign cur_valid  = in_valid[cur_q];
    assign xfer       = (state_q == BURST) && cur_valid && can_load;
    assign credit_dec = xfer && (!PACKET_MODE || in_last[cur_q]);
    // In beat mode a channel that stops while it could send gives up its
    // grant. In packet mode only the packet's end can release the grant.
    assign burst_end  = (credit_dec && (credit_q == WEIGHT_W'(1)))
                     || (!PACKET_MODE && (state_q == BURST) && can_load && !cur_valid);
    assign next_ptr   = (cur_q == CH_W'(NUM_CH - 1)) ? '0 : cur_q + 1'b1;

    always_comb begin
        in_ready = '0;
        if (state_q == BURST) begin
            in_ready[cur_q] = can_load;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only. Every
    // register sees the values from before the edge, whatever the statement
    // order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            ptr_q       <= '0;
            credit_q    <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_last_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        cur_q    <= pick;
                        credit_q <= weight_eff[pick];
                        state_q  <= BURST;
                    end
                end
                BURST: begin
                    if (credit_dec) begin
                        credit_q <= credit_q - 1'b1;
                    end
                    if (burst_end) begin
                        state_q <= IDLE;
                        ptr_q   <= next_ptr;
                    end
                end
            endcase

            // A load and a drain in the same cycle keep the register full.
            // This gives one beat per cycle.
            if (xfer) begin
                out_valid_q <= 1'b1;
                out_data_q  <= data_ch[cur_q];
                out_ch_q    <= cur_q;
                out_last_q  <= PACKET_MODE ? in_last[cur_q] : 1'b1;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_last  = out_last_q;

endmodule

// File: tb/tb_weighted_rr_arbiter.sv
// tb_weighted_rr_arbiter
//
// Two arbiters run side by side on one clock:
//   instance 0 (beat mode):   4 channels, weights {0,2,3,1}
//   instance 1 (packet mode): 3 channels, weights {1,2,1}
// Producers present pre-generated beats with random valid gaps. The sink
// applies random backpressure. A behavioural model tracks the grant owner,
// the weight still to spend and the one-slot output. It predicts in_ready and
// the output register every cycle. A separate per-channel order check makes
// sure that every drained beat is the next unsent one of its channel. Midway
// through, reset is pulsed while the output register is full.

module tb_weighted_rr_arbiter;

    localparam int NB        = 4;
    localparam int NP        = 3;
    localparam int BEAT_WT [NB] = '{0, 2, 3, 1};
    localparam int PKT_WT  [NP] = '{1, 2, 1};
    localparam int MAXB      = 40;
    localparam int LIMIT     = 5000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT wiring
    logic [NB-1:0]    b_valid, b_ready, b_last;
    logic [NB*8-1:0]  b_data;
    logic             b_ovalid, b_oready, b_olast;
    logic [7:0]       b_odata;
    logic [1:0]       b_och;

    logic [NP-1:0]    p_valid, p_ready, p_last;
    logic [NP*8-1:0]  p_data;
    logic             p_ovalid, p_oready, p_olast;
    logic [7:0]       p_odata;
    logic [1:0]       p_och;

    weighted_rr_arbiter #(
        .NUM_CH(NB), .DATA_W(8), .WEIGHT_W(4), .WEIGHTS(BEAT_WT), .PACKET_MODE(1'b0)
    ) u_beat (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_valid), .in_ready(b_ready), .in_data(b_data), .in_last(b_last),
        .out_valid(b_ovalid), .out_ready(b_oready), .out_data(b_odata),
        .out_ch(b_och), .out_last(b_olast)
    );

    weighted_rr_arbiter #(
        .NUM_CH(NP), .DATA_W(8), .WEIGHT_W(4), .WEIGHTS(PKT_WT), .PACKET_MODE(1'b1)
    ) u_pkt (
        .clk(clk), .rst_n(rst_n),
        .in_valid(p_valid), .in_ready(p_ready), .in_data(p_data), .in_last(p_last),
        .out_valid(p_ovalid), .out_ready(p_oready), .out_data(p_odata),
        .out_ch(p_och), .out_last(p_olast)
    );

    // Per-instance drive and observe arrays (index 0 = beat, 1 = packet)
    logic [3:0] drv_valid [2];
    logic [3:0] drv_last  [2];
    logic [7:0] drv_data  [2][4];
    logic       drv_oready[2];

    assign b_valid  = drv_valid[0];
    assign b_last   = drv_last[0];
    assign b_data   = {drv_data[0][3], drv_data[0][2], drv_data[0][1], drv_data[0][0]};
    assign b_oready = drv_oready[0];
    assign p_valid  = drv_valid[1][NP-1:0];
    assign p_last   = drv_last[1][NP-1:0];
    assign p_data   = {drv_data[1][2], drv_data[1][1], drv_data[1][0]};
    assign p_oready = drv_oready[1];

    logic [3:0] obs_ready [2];
    logic       obs_ovalid[2];
    logic [7:0] obs_odata [2];
    logic [1:0] obs_och   [2];
    logic       obs_olast [2];

    assign obs_ready[0]  = b_ready;
    assign obs_ready[1]  = {1'b0, p_ready};
    assign obs_ovalid[0] = b_ovalid;
    assign obs_ovalid[1] = p_ovalid;
    assign obs_odata[0]  = b_odata;
    assign obs_odata[1]  = p_odata;
    assign obs_och[0]    = b_och;
    assign obs_och[1]    = p_och;
    assign obs_olast[0]  = b_olast;
    assign obs_olast[1]  = p_olast;

    int    nch [2] = '{NB, NP};
    string nm  [2] = '{"beat", "pkt"};

    // Checking
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Producer content: every beat carries {channel, index} so order is traceable.
    logic [7:0] g_data [2][4][MAXB];
    bit         g_last [2][4][MAXB];
    int         g_cnt  [2][4];
    int         sent   [2][4];
    int         drained[2][4];

    task automatic init_sources(input int k);
        for (int c = 0; c < 4; c++) begin
            int rem;
            rem = 0;
            g_cnt[k][c]   = (c < nch[k]) ? int'($urandom_range(20, MAXB - 10)) : 0;
            sent[k][c]    = 0;
            drained[k][c] = 0;
            for (int i = 0; i < g_cnt[k][c]; i++) begin
                if (rem == 0) rem = int'($urandom_range(1, 4));
                rem--;
                g_data[k][c][i] = 8'(c * 64 + i);
                g_last[k][c][i] = (rem == 0) || (i == g_cnt[k][c] - 1);
            end
        end
    endtask

    // Reference model: who owns the grant, how much weight is left, where
    // the next search begins, and what sits in the one-slot output.
    int         m_owner[2];
    int         m_left [2];
    int         m_start[2];
    bit         m_full [2];
    logic [7:0] m_data [2];
    int         m_ch   [2];
    bit         m_last [2];

    function automatic int weight_of(input int k, input int c);
        int w;
        w = (k == 0) ? BEAT_WT[c] : PKT_WT[c];
        return (w < 1) ? 1 : w;
    endfunction

    task automatic model_reset(input int k);
        m_owner[k] = -1;
        m_left[k]  = 0;
        m_start[k] = 0;
        m_full[k]  = 0;
        m_data[k]  = 8'h00;
        m_ch[k]    = 0;
        m_last[k]  = 0;
    endtask

    function automatic logic [3:0] exp_ready(input int k);
        logic [3:0] r;
        r = 4'b0000;
        if (m_owner[k] >= 0 && (!m_full[k] || drv_oready[k])) r[m_owner[k]] = 1'b1;
        return r;
    endfunction

    task automatic model_step(input int k);
        bit can_take;
        bit took;
        can_take = !m_full[k] || drv_oready[k];
        took     = 0;
        if (m_owner[k] < 0) begin
            for (int i = 0; i < nch[k]; i++) begin
                int c;
                c = (m_start[k] + i) % nch[k];
                if (drv_valid[k][c]) begin
                    m_owner[k] = c;
                    m_left[k]  = weight_of(k, c);
                    break;
                end
            end
        end else begin
            int c;
            c    = m_owner[k];
            took = drv_valid[k][c] && can_take;
            if (took) begin
                m_data[k] = drv_data[k][c];
                m_ch[k]   = c;
                m_last[k] = (k == 0) ? 1'b1 : drv_last[k][c];
                if (k == 0 || drv_last[k][c]) m_left[k]--;
            end
            if ((took && m_left[k] == 0) || (k == 0 && can_take && !drv_valid[k][c])) begin
                m_start[k] = (c + 1) % nch[k];
                m_owner[k] = -1;
            end
        end
        if (took) m_full[k] = 1;
        else if (drv_oready[k]) m_full[k] = 0;
    endtask

    // Stimulus and per-cycle checks
    task automatic drive_random(input int k);
        for (int c = 0; c < 4; c++) begin
            drv_valid[k][c] = 1'b0;
            drv_last[k][c]  = 1'b0;
            drv_data[k][c]  = 8'hEE;
            if (c < nch[k] && sent[k][c] < g_cnt[k][c]) begin
                drv_valid[k][c] = ($urandom_range(0, 99) < 70);
                drv_data[k][c]  = g_data[k][c][sent[k][c]];
                drv_last[k][c]  = g_last[k][c][sent[k][c]];
            end
        end
        drv_oready[k] = ($urandom_range(0, 99) < 75);
    endtask

    task automatic check_cycle(input int k, output logic [3:0] accepted);
        int c;
        check({nm[k], ".in_ready"}, 32'(obs_ready[k]), 32'(exp_ready(k)));
        check({nm[k], ".out_valid"}, 32'(obs_ovalid[k]), 32'(m_full[k]));
        if (m_full[k]) begin
            check({nm[k], ".out_data"}, 32'(obs_odata[k]), 32'(m_data[k]));
            check({nm[k], ".out_ch"},   32'(obs_och[k]),   32'(m_ch[k]));
            check({nm[k], ".out_last"}, 32'(obs_olast[k]), 32'(m_last[k]));
        end
        accepted = obs_ready[k] & drv_valid[k];
        // Order check independent of the model: the drained beat must be the
        // next one its channel produced.
        if (obs_ovalid[k] && drv_oready[k]) begin
            c = int'(obs_och[k]);
            if (c >= nch[k]) begin
                check({nm[k], ".out_ch_range"}, 32'(c), 32'(nch[k] - 1));
            end else if (drained[k][c] >= g_cnt[k][c]) begin
                check({nm[k], ".extra_beat"}, 32'(drained[k][c]), 32'(g_cnt[k][c] - 1));
            end else begin
                check({nm[k], ".order"}, 32'(obs_odata[k]), 32'(g_data[k][c][drained[k][c]]));
                drained[k][c]++;
            end
        end
    endtask

    task automatic check_zero(input string when);
        for (int k = 0; k < 2; k++) begin
            check({nm[k], when, ".out_valid"}, 32'(obs_ovalid[k]), 32'd0);
            check({nm[k], when, ".out_data"},  32'(obs_odata[k]),  32'd0);
            check({nm[k], when, ".out_ch"},    32'(obs_och[k]),    32'd0);
            check({nm[k], when, ".out_last"},  32'(obs_olast[k]),  32'd0);
            check({nm[k], when, ".in_ready"},  32'(obs_ready[k]),  32'd0);
        end
    endtask

    function automatic bit all_drained();
        for (int k = 0; k < 2; k++)
            for (int c = 0; c < 4; c++)
                if (drained[k][c] != g_cnt[k][c]) return 1'b0;
        return 1'b1;
    endfunction

    initial begin
        logic [3:0] acc [2];
        bit done;
        bit did_reset;

        for (int k = 0; k < 2; k++) begin
            drv_valid[k]  = 4'b0000;
            drv_last[k]   = 4'b0000;
            drv_oready[k] = 1'b1;
            for (int c = 0; c < 4; c++) drv_data[k][c] = 8'h00;
            init_sources(k);
            model_reset(k);
        end

        // Reset state, with requests present so reset must dominate them.
        drv_valid[0] = 4'b1111;
        drv_valid[1] = 4'b0111;
        repeat (3) @(posedge clk);
        #1;
        check_zero(".reset");
        rst_n = 1'b1;

        done      = 0;
        did_reset = 0;
        for (int cyc = 0; cyc < LIMIT && !done; cyc++) begin
            drive_random(0);
            drive_random(1);
            #3;
            check_cycle(0, acc[0]);
            check_cycle(1, acc[1]);
            if (!did_reset && cyc > 60 && obs_ovalid[0]) begin
                // Asynchronous reset while a beat is held: it must vanish now.
                did_reset = 1;
                rst_n = 1'b0;
                #1;
                check_zero(".midreset");
                for (int k = 0; k < 2; k++) begin
                    init_sources(k);
                    model_reset(k);
                end
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                continue;
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                model_step(k);
                for (int c = 0; c < 4; c++) if (acc[k][c]) sent[k][c]++;
            end
            #1;
            done = all_drained();
        end
        check("mid_burst_reset_seen", 32'(did_reset), 32'd1);
        check("all_beats_drained", 32'(done), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/weighted_rr_arbiter.md
# weighted_rr_arbiter

Parametrised N-channel weighted round-robin arbiter with valid/ready inputs and a single registered valid/ready output. Each channel gets a per-channel weight from an unpacked-array parameter port, which sets how many consecutive beats (beat mode) or packets (packet mode) it may send before the grant rotates. It sits between multiple producer streams and a shared downstream sink. It is the generalisation of our fixed two-input mux: configurable channel count, width, weights and grant mode.

## Interface
- NUM_CH, 4: number of input channels, 2..16.
- DATA_W, 8: data width per channel.
- WEIGHT_W, 4: width of the credit counter and of each weight.
- WEIGHTS[NUM_CH], '{1,1,1,1}: per-channel weight, an unpacked `int` array. A weight of 0 is treated as 1.
- PACKET_MODE, 0: 0 = credits count beats; 1 = credits count packets, delimited by in_last.
- clk  input  1  clock; all logic is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  NUM_CH  per-channel valid.
- in_ready  output  NUM_CH  per-channel ready; one-hot or zero.
- in_data  input  NUM_CH*DATA_W  channel i occupies bits [i*DATA_W +: DATA_W].
- in_last  input  NUM_CH  per-channel end-of-packet; ignored when PACKET_MODE=0.
- out_valid  output  1  output register holds a beat.
- out_ready  input  1  downstream accepts the beat.
- out_data  output  DATA_W  registered data.
- out_ch  output  $clog2(NUM_CH)  source channel of out_data.
- out_last  output  1  registered copy of in_last; forced to 1 when PACKET_MODE=0.

## Operation
- State is held in: FSM {IDLE, BURST}, cur (granted channel), ptr (next search start), credit (WEIGHT_W bits), and a 1-entry output register.
- **Reset values:** IDLE, ptr=0, cur=0, credit=0, out_valid=0, out_data=0, out_ch=0, out_last=0, in_ready=0.
- **IDLE:**
  - Search in_valid starting at ptr, wrapping modulo NUM_CH. The first asserted channel c wins.
  - Next edge: cur=c, credit=max(WEIGHTS[c],1), state goes to BURST.
  - No valid input: stay in IDLE.
  - in_ready=0 throughout IDLE.
- **BURST:**
  - in_ready[cur] = !out_valid || out_ready. All other bits are 0.
  - Transfer = in_valid[cur] && in_ready[cur]. On a transfer the output register loads in_data[cur], cur and in_last[cur].
  - Credit decrements on every transfer (beat mode), or on a transfer with in_last=1 (packet mode).
- **Exit from BURST** (ptr = cur+1 mod NUM_CH, state goes to IDLE) on the edge where either:
  - a decrementing transfer takes credit to 0; or
  - in beat mode only, in_valid[cur]=0 while in_ready[cur]=1 (the channel stops).
- In packet mode the grant is never released mid-packet. An idle cur channel holds the grant until its packet completes.
- **Output register:**
  - out_valid clears on out_ready when there is no simultaneous load.
  - Load and drain in the same cycle is allowed, giving full throughput.
  - The output holds stable while out_valid && !out_ready.
- **Simultaneous events:** with multiple requesters, the lowest index at or after ptr wins. A new request arriving during BURST waits for the rotation.
- **rst_n asserted mid-burst:** all state clears immediately and asynchronously. Any beat in the output register is dropped. Deassertion is synchronised externally.

## Timing
- Request to first in_ready: 1 cycle (the IDLE select cycle).
- Input accept to out_valid: 1 cycle.
- Steady state: 1 beat per cycle within a burst.
- One IDLE bubble cycle between grants.
- A burst of weight W in beat mode occupies W+1 cycles, including the select cycle.
- ptr wraps from NUM_CH-1 to 0.
- out_* change only on a rising clk edge, or asynchronously on reset.

## Test plan
- **Single channel, beat mode:** NUM_CH=4, WEIGHTS='{3,1,1,1}, ch0 streams 5 beats 0x10..0x14 with out_ready=1.
  - Outputs 0x10..0x12 on out_ch=0, then an IDLE bubble, then 0x13..0x14.
  - in_ready[0] is low for exactly one cycle between the two groups.
- **All channels, beat mode:** WEIGHTS='{1,2,3,4}, all four channels request continuously.
  - out_ch sequence per round is 0,1,1,2,2,2,3,3,3,3, repeating.
  - ptr wraps to 0 after ch3.
- **Backpressure:** out_ready held low for 3 cycles mid-burst.
  - out_data/out_ch hold stable.
  - in_ready[cur]=0 while blocked.
  - No beat is lost or duplicated; credit is unchanged during the stall.
- **Packet mode:** PACKET_MODE=1, WEIGHTS='{1,1,1,1}.
  - ch1 sends a 4-beat packet with a 2-cycle in_valid gap; ch2 requests throughout.
  - The grant stays on ch1 through the gap and ends after in_last; the next grant goes to ch2.
  - out_last=1 only on beat 4.
- **Weight 0 and early stop:** WEIGHTS='{0,2,1,1}.
  - ch0 gets exactly 1 beat.
  - If ch1 drops in_valid after 1 beat in beat mode, the arbiter rotates to ch2 on that edge.
- **Reset mid-burst:** pull rst_n low while out_valid=1.
  - out_valid, out_data, out_ch, out_last and in_ready go to 0 immediately.
  - After release, the first grant searches from ch0.
